// File: rtl/mtl_display_ctrl_param.sv
// MTL panel controller: HD/VD/DE timing, valid/ready pixel intake, Avalon-MM regs.
// Optional colour-bar generator built only when MTL_TESTPAT_EN is defined.
module mtl_display_ctrl_param #(
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = 800,
    parameter int H_BLANK  = 46,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 1,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 23,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 1,
    parameter int ADDR_W   = 3
) (
    input  logic                   iCLK,
    input  logic                   iRST_n,
    input  logic [ADDR_W-1:0]      avs_address,
    input  logic                   avs_read,
    output logic [31:0]            avs_readdata,
    input  logic                   avs_write,
    input  logic [31:0]            avs_writedata,
    input  logic [3*COLOR_W-1:0]   iPIX_DATA,
    input  logic                   iPIX_VALID,
    output logic                   oPIX_READY,
    output logic                   oNewFrame,
    output logic                   oEndFrame,
    output logic                   oIRQ,
    output logic                   oHD,
    output logic                   oVD,
    output logic                   oDE,
    output logic [COLOR_W-1:0]     oLCD_R,
    output logic [COLOR_W-1:0]     oLCD_G,
    output logic [COLOR_W-1:0]     oLCD_B
);

    localparam int PW     = 3 * COLOR_W;
    localparam int H_LINE = H_BLANK + H_ACTIVE + H_FP;
    localparam int V_LINE = V_BLANK + V_ACTIVE + V_FP;

    localparam logic [15:0] X_LAST = 16'(H_LINE - 1);
    localparam logic [15:0] Y_LAST = 16'(V_LINE - 1);
    localparam logic [15:0] X_ACT0 = 16'(H_BLANK);
    localparam logic [15:0] X_ACT1 = 16'(H_BLANK + H_ACTIVE);
    localparam logic [15:0] Y_ACT0 = 16'(V_BLANK);
    localparam logic [15:0] Y_ACT1 = 16'(V_BLANK + V_ACTIVE);
    localparam logic [15:0] X_EOF  = 16'(H_BLANK + H_ACTIVE - 1);
    localparam logic [15:0] Y_EOF  = 16'(V_BLANK + V_ACTIVE - 1);
    localparam logic [15:0] X_HS   = 16'(H_SYNC);
    localparam logic [15:0] Y_VS   = 16'(V_SYNC);

    logic [15:0]   x_q, x_d, y_q, y_d;
    logic          x_wrap, h_act, v_act, active;
    logic          new_frame, end_frame;
    logic          pix_ready, underrun, test_on, tp_rd;
    logic          en_q, en_d, irq_en_q, irq_en_d;
    logic          sh_en_q, sh_en_d;
    logic [PW-1:0] bg_q, bg_d, sh_bg_q, sh_bg_d;
    logic          uf_q, uf_d, ip_q, ip_d;
    logic [31:0]   fc_q, fc_d, rd_q, rd_d;
    logic          hd_q, hd_d, vd_q, vd_d, de_q, de_d;
    logic [PW-1:0] rgb_q, rgb_d, bar_rgb;
    logic          wr_ctrl, wr_bg, wr_stat;
    logic          unused_wd;

    assign unused_wd = ^avs_writedata;

    always_comb begin
        x_wrap = (x_q == X_LAST);
        x_d    = x_wrap ? 16'd0 : x_q + 16'd1;
        y_d    = y_q;
        if (x_wrap) begin
            y_d = (y_q == Y_LAST) ? 16'd0 : y_q + 16'd1;
        end
        h_act     = (x_q >= X_ACT0) && (x_q < X_ACT1);
        v_act     = (y_q >= Y_ACT0) && (y_q < Y_ACT1);
        active    = h_act && v_act;
        new_frame = (x_q == 16'd0) && (y_q == 16'd0);
        end_frame = (x_q == X_EOF) && (y_q == Y_EOF);
    end

`ifdef MTL_TESTPAT_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic        tp_q, tp_d, sh_tp_q, sh_tp_d;
    logic [15:0] bar_x, bar_n;
    logic [2:0]  bar_idx, bar_bits;

    assign test_on = sh_tp_q;
    assign tp_rd   = tp_q;

    always_comb begin
        tp_d    = tp_q;
        sh_tp_d = sh_tp_q;
        if (wr_ctrl) tp_d = avs_writedata[2];
        if (new_frame) sh_tp_d = tp_q;
    end

    // Bars past the eighth (H_ACTIVE not a multiple of 8) stay black.
    always_comb begin
        bar_x   = x_q - X_ACT0;
        bar_n   = bar_x / 16'(BAR_W);
        bar_idx = (bar_n > 16'd7) ? 3'd7 : bar_n[2:0];
        case (bar_idx)
            3'd0:    bar_bits = 3'b111;
            3'd1:    bar_bits = 3'b110;
            3'd2:    bar_bits = 3'b011;
            3'd3:    bar_bits = 3'b010;
            3'd4:    bar_bits = 3'b101;
            3'd5:    bar_bits = 3'b100;
            3'd6:    bar_bits = 3'b001;
            default: bar_bits = 3'b000;
        endcase
        bar_rgb = {{COLOR_W{bar_bits[2]}},
                   {COLOR_W{bar_bits[1]}},
                   {COLOR_W{bar_bits[0]}}};
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            tp_q    <= 1'b0;
            sh_tp_q <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            sh_tp_q <= sh_tp_d;
        end
    end
`else
    assign test_on = 1'b0;
    assign tp_rd   = 1'b0;
    assign bar_rgb = '0;
`endif

    assign pix_ready = active && sh_en_q && !test_on;
    assign underrun  = pix_ready && !iPIX_VALID;

    assign wr_ctrl = avs_write && (avs_address == ADDR_W'(0));
    assign wr_bg   = avs_write && (avs_address == ADDR_W'(1));
    assign wr_stat = avs_write && (avs_address == ADDR_W'(2));

    // Shadows take the pre-write live value; a same-cycle write waits a frame.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        bg_d     = bg_q;
        sh_en_d  = sh_en_q;
        sh_bg_d  = sh_bg_q;
        if (wr_ctrl) begin
            en_d     = avs_writedata[0];
            irq_en_d = avs_writedata[1];
        end
        if (wr_bg) bg_d = avs_writedata[PW-1:0];
        if (new_frame) begin
            sh_en_d = en_q;
            sh_bg_d = bg_q;
        end
        uf_d = underrun  | (uf_q & ~(wr_stat & avs_writedata[0]));
        ip_d = end_frame | (ip_q & ~(wr_stat & avs_writedata[1]));
        fc_d = fc_q + {31'd0, end_frame};
    end

    always_comb begin
        rd_d = rd_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_W'(0): rd_d = {29'd0, tp_rd, irq_en_q, en_q};
                ADDR_W'(1): rd_d = 32'(bg_q);
                ADDR_W'(2): rd_d = {29'd0, ~v_act, ip_q, uf_q};
                ADDR_W'(3): rd_d = fc_q;
                ADDR_W'(4): rd_d = {5'd0, y_q[10:0], 5'd0, x_q[10:0]};
                default:    rd_d = 32'd0;
            endcase
        end
    end

    always_comb begin
        hd_d  = (x_q >= X_HS);
        vd_d  = (y_q >= Y_VS);
        de_d  = active;
        rgb_d = '0;
        if (active) begin
            if (test_on)
                rgb_d = bar_rgb;
            else if (pix_ready && iPIX_VALID)
                rgb_d = iPIX_DATA;
            else
                rgb_d = sh_bg_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q      <= '0;
            y_q      <= '0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            sh_en_q  <= 1'b0;
            bg_q     <= '0;
            sh_bg_q  <= '0;
            uf_q     <= 1'b0;
            ip_q     <= 1'b0;
            fc_q     <= '0;
            rd_q     <= '0;
            hd_q     <= 1'b0;
            vd_q     <= 1'b0;
            de_q     <= 1'b0;
            rgb_q    <= '0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            sh_en_q  <= sh_en_d;
            bg_q     <= bg_d;
            sh_bg_q  <= sh_bg_d;
            uf_q     <= uf_d;
            ip_q     <= ip_d;
            fc_q     <= fc_d;
            rd_q     <= rd_d;
            hd_q     <= hd_d;
            vd_q     <= vd_d;
            de_q     <= de_d;
            rgb_q    <= rgb_d;
        end
    end

    assign oPIX_READY   = pix_ready;
    assign oNewFrame    = new_frame;
    assign oEndFrame    = end_frame;
    assign oIRQ         = ip_q && irq_en_q;
    assign avs_readdata = rd_q;
    assign oHD          = hd_q;
    assign oVD          = vd_q;
    assign oDE          = de_q;
    assign oLCD_R       = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign oLCD_G       = rgb_q[2*COLOR_W-1:COLOR_W];
    assign oLCD_B       = rgb_q[COLOR_W-1:0];

endmodule
